stream_rr_arbiter: RTL and testbench

- Packet-level round-robin arbiter that shares one downstream stream sink, typically a single StreamFifo, between NCH upstream stream sources.
- A granted source keeps the output until it transfers its last beat; ownership then rotates to the next requesting source.
- Sits in front of the shared FIFO and tags every beat with the owning channel index.

---
 rtl/stream_rr_arbiter.sv | 132 +++++++++++++
 tb/tb_stream_rr_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_rr_arbiter.sv
// Packet-level round-robin arbiter that shares one stream sink between NCH sources and tags beats with the channel index.
// Define STREAM_RR_ARB_OUT_REG_EN to insert a registered output slice (one extra cycle of latency, full throughput).
module stream_rr_arbiter #(
    parameter int DW  = 32,
    parameter int NCH = 4,
    localparam int IW = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    input  logic [NCH-1:0]    in_last,
    output logic [NCH-1:0]    in_ready,
    output logic [DW-1:0]     out_data,
    output logic              out_last,
    output logic [IW-1:0]     out_id,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] grant;
    logic [IW-1:0] next_grant;
    logic [IW-1:0] idx;
    logic          any_req;
    logic          locked;
    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic          release_beat;

    assign locked    = (state == LOCK);
    assign sel_valid = in_valid[grant];
    assign sel_last  = in_last[grant];
    assign sel_data  = in_data[int'(grant)*DW +: DW];

    // First requester at or after rr_ptr, searching upward with wrap.
    always_comb begin
        next_grant = rr_ptr;
        any_req    = 1'b0;
        idx        = '0;
        for (int i = 0; i < NCH; i++) begin
            idx = IW'((int'(rr_ptr) + i) % NCH);
            if (!any_req && in_valid[idx]) begin
                next_grant = idx;
                any_req    = 1'b1;
            end
        end
    end

`ifdef STREAM_RR_ARB_OUT_REG_EN
    logic accept;
    logic take;

    assign accept       = ~out_valid | out_ready;
    assign take         = locked & sel_valid & accept;
    assign release_beat = take & sel_last;

    always_comb begin
        in_ready = '0;
        if (locked) begin
            in_ready[grant] = accept;
        end
    end

    // Output slice: refills on the same cycle it drains, so a packet streams without gaps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_id    <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_id    <= grant;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
`else
    assign release_beat = locked & sel_valid & out_ready & sel_last;
    assign out_valid    = locked & sel_valid;
    assign out_last     = locked & sel_last;
    assign out_data     = locked ? sel_data : '0;
    assign out_id       = locked ? grant : '0;

    always_comb begin
        in_ready = '0;
        if (locked) begin
            in_ready[grant] = out_ready;
        end
    end
`endif

    // IDLE spends one bubble cycle choosing a channel; LOCK holds it until its last beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant <= next_grant;
                        state <= LOCK;
                        busy  <= 1'b1;
                    end
                end
                LOCK: begin
                    if (release_beat) begin
                        rr_ptr <= (grant == IW'(NCH - 1)) ? '0 : grant + IW'(1);
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scoreboard bench for stream_rr_arbiter: per-channel source queues drive the DUT, a monitor checks every output beat.
// Also covers the STREAM_RR_ARB_OUT_REG_EN build where timing differs.
module tb_stream_rr_arbiter;

    localparam int DW  = 32;
    localparam int NCH = 4;
    localparam int IW  = 2;
`ifdef STREAM_RR_ARB_OUT_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            hole;
    } beat_t;

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            id;
        int            gap;
        int            at;
    } exp_t;

    logic              clk;
    logic              rst;
    logic [NCH*DW-1:0] in_data;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_last;
    logic [NCH-1:0]    in_ready;
    logic [DW-1:0]     out_data;
    logic              out_last;
    logic [IW-1:0]     out_id;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    beat_t src_q[NCH][$];
    exp_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;

    stream_rr_arbiter #(.DW(DW), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int ch, input logic [DW-1:0] base, input int n,
                                 input int hole_beat, input int hole_len);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.data = base + DW'(i);
            b.last = (i == n - 1);
            b.hole = (i == hole_beat) ? hole_len : 0;
            src_q[ch].push_back(b);
        end
    endtask

    task automatic expect_beat(input logic [DW-1:0] d, input logic l, input int id,
                               input int gap, input int at);
        exp_t e;
        e.data = d;
        e.last = l;
        e.id   = id;
        e.gap  = gap;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            wait_cycles(1);
            n++;
        end
        checkOutput(name, 64'(exp_q.size()), 64'd0);
        wait_cycles(2);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
    task automatic doReset();
        rst = 1'b1;
        #1;
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_in_ready", 64'(in_ready), 64'd0);
        checkOutput("rst_out_data", 64'(out_data), 64'd0);
        checkOutput("rst_out_last", 64'(out_last), 64'd0);
        checkOutput("rst_out_id", 64'(out_id), 64'd0);
        for (int k = 0; k < NCH; k++) src_q[k].delete();
        exp_q.delete();
        @(negedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Source driver: presents queue heads, honours holes, pops beats seen transferred.
    initial begin
        logic [NCH-1:0] fire_cap;
        beat_t          b;
        fire_cap = '0;
        in_valid = '0;
        in_data  = '0;
        in_last  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NCH; k++) begin
                if (fire_cap[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
                in_valid[k]          = 1'b0;
                in_last[k]           = 1'b0;
                in_data[k*DW +: DW]  = '0;
                if (src_q[k].size() > 0) begin
                    b = src_q[k][0];
                    if (b.hole > 0) begin
                        b.hole--;
                        src_q[k][0] = b;
                    end else begin
                        in_valid[k]         = 1'b1;
                        in_last[k]          = b.last;
                        in_data[k*DW +: DW] = b.data;
                    end
                end
            end
            #4;
            fire_cap = in_valid & in_ready;
        end
    end

    // Monitor: samples one time unit before each rising edge and scores every output transfer.
    initial begin
        int   last_cyc;
        int   busy_exp;
        exp_t e;
        last_cyc = 0;
        busy_exp = -1;
        forever begin
            @(negedge clk);
            #4;
            cyc++;
            if (rst) begin
                busy_exp = -1;
            end else begin
                if (busy_exp >= 0) begin
                    checkOutput("busy_after_beat", 64'(busy), 64'(busy_exp));
                    busy_exp = -1;
                end
                checkOutput("in_ready_onehot", 64'($countones(in_ready) <= 1), 64'd1);
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_beat: got data 0x%0h id %0d, expected no beat", out_data, out_id);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("out_data", 64'(out_data), 64'(e.data));
                        checkOutput("out_last", 64'(out_last), 64'(e.last));
                        checkOutput("out_id", 64'(out_id), 64'(e.id));
                        if (e.gap >= 0) checkOutput("beat_gap", 64'(cyc - last_cyc), 64'(e.gap));
                        if (e.at >= 0) checkOutput("first_beat_cycle", 64'(cyc), 64'(e.at));
`ifndef STREAM_RR_ARB_OUT_REG_EN
                        busy_exp = e.last ? 0 : 1;
`endif
                    end
                    last_cyc = cyc;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
        rst       = 1'b1;
        out_ready = 1'b1;
        wait_cycles(1);
        doReset();

        // Single 3-beat packet on ch2: one bubble, then back-to-back beats.
        c0 = cyc;
        applyStimulus(2, 32'hA0, 3, -1, 0);
        expect_beat(32'hA0, 1'b0, 2, -1, c0 + LAT);
        expect_beat(32'hA1, 1'b0, 2, 1, -1);
        expect_beat(32'hA2, 1'b1, 2, 1, -1);
        wait_drain("drain_ch2_packet", 50);

        // rr_ptr is now 3: ch3 beats ch0 when both request together.
        c0 = cyc;
        applyStimulus(0, 32'hB0, 1, -1, 0);
        applyStimulus(3, 32'hB3, 1, -1, 0);
        expect_beat(32'hB3, 1'b1, 3, -1, c0 + LAT);
        expect_beat(32'hB0, 1'b1, 0, 2, -1);
        wait_drain("drain_ptr3", 50);

        // Fairness with all channels holding single-beat packets.
        doReset();
        c0 = cyc;
        applyStimulus(0, 32'hC0, 1, -1, 0);
        applyStimulus(0, 32'hC4, 1, -1, 0);
        applyStimulus(1, 32'hC1, 1, -1, 0);
        applyStimulus(1, 32'hC5, 1, -1, 0);
        applyStimulus(2, 32'hC2, 1, -1, 0);
        applyStimulus(3, 32'hC3, 1, -1, 0);
        expect_beat(32'hC0, 1'b1, 0, -1, c0 + LAT);
        expect_beat(32'hC1, 1'b1, 1, 2, -1);
        expect_beat(32'hC2, 1'b1, 2, 2, -1);
        expect_beat(32'hC3, 1'b1, 3, 2, -1);
        expect_beat(32'hC4, 1'b1, 0, 2, -1);
        expect_beat(32'hC5, 1'b1, 1, 2, -1);
        wait_drain("drain_fairness", 80);

        // ch1 locked with a valid hole while ch0 waits; ch0 follows only after ch1's last beat.
        c0 = cyc;
        applyStimulus(1, 32'hD0, 4, 2, 2);
        expect_beat(32'hD0, 1'b0, 1, -1, c0 + LAT);
        expect_beat(32'hD1, 1'b0, 1, 1, -1);
        expect_beat(32'hD2, 1'b0, 1, 3, -1);
        expect_beat(32'hD3, 1'b1, 1, 1, -1);
        expect_beat(32'hE0, 1'b1, 0, 2, -1);
        wait_cycles(2);
        applyStimulus(0, 32'hE0, 1, -1, 0);
        wait_cycles(2);
        checkOutput("hole_busy_a", 64'(busy), 64'd1);
        checkOutput("hole_in_ready_a", 64'(in_ready), 64'b0010);
        checkOutput("hole_out_valid_a", 64'(out_valid), 64'd0);
        wait_cycles(1);
        checkOutput("hole_busy_b", 64'(busy), 64'd1);
        checkOutput("hole_in_ready_b", 64'(in_ready), 64'b0010);
        wait_drain("drain_mid_packet", 80);

        // out_ready toggling during a 4-beat ch3 packet.
        applyStimulus(3, 32'hF0, 4, -1, 0);
        expect_beat(32'hF0, 1'b0, 3, -1, -1);
        expect_beat(32'hF1, 1'b0, 3, -1, -1);
        expect_beat(32'hF2, 1'b0, 3, -1, -1);
        expect_beat(32'hF3, 1'b1, 3, -1, -1);
        for (int i = 0; i < 12; i++) begin
            out_ready = (i % 2 == 0);
            #1;
`ifdef STREAM_RR_ARB_OUT_REG_EN
            checkOutput("in_ready_mirror", 64'(in_ready),
                        busy ? 64'({(~out_valid | out_ready), 3'b000}) : 64'd0);
`else
            checkOutput("in_ready_mirror", 64'(in_ready), busy ? 64'({out_ready, 3'b000}) : 64'd0);
`endif
            wait_cycles(1);
        end
        out_ready = 1'b1;
        wait_drain("drain_toggle", 50);

        // 5-beat ch0 packet with a 2-cycle sink stall in the middle.
        c0 = cyc;
        applyStimulus(0, 32'h10, 5, -1, 0);
        expect_beat(32'h10, 1'b0, 0, -1, c0 + LAT);
        expect_beat(32'h11, 1'b0, 0, -1, -1);
        expect_beat(32'h12, 1'b0, 0, -1, -1);
        expect_beat(32'h13, 1'b0, 0, 1, -1);
        expect_beat(32'h14, 1'b1, 0, 1, -1);
        wait_cycles(3);
        out_ready = 1'b0;
        #1;
        checkOutput("stall_in_ready_a", 64'(in_ready), 64'd0);
        checkOutput("stall_out_valid", 64'(out_valid), 64'd1);
        wait_cycles(1);
        checkOutput("stall_in_ready_b", 64'(in_ready), 64'd0);
        wait_cycles(1);
        out_ready = 1'b1;
        wait_drain("drain_stall", 50);

        // Reset while locked on ch1 (rr_ptr=1); afterwards the search restarts at 0.
        applyStimulus(1, 32'h20, 3, -1, 0);
        expect_beat(32'h20, 1'b0, 1, -1, -1);
        expect_beat(32'h21, 1'b0, 1, 1, -1);
        wait_cycles(3);
        checkOutput("locked_before_reset", 64'(busy), 64'd1);
        doReset();
        c0 = cyc;
        applyStimulus(0, 32'h30, 1, -1, 0);
        applyStimulus(3, 32'h33, 1, -1, 0);
        expect_beat(32'h30, 1'b1, 0, -1, c0 + LAT);
        expect_beat(32'h33, 1'b1, 3, 2, -1);
        wait_drain("drain_after_reset", 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
